// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the IF/ID
// pipeline register with a fetched word or a NOP bubble.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [2:0]  JumpFlag,
    input  logic [31:0] BranchAddr,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] JrAddr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_plus4_id,
    output logic        valid_id
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned JF_W      = 3;
    localparam int unsigned JF_BRANCH = 0;
    localparam int unsigned JF_JUMP   = 1;
    localparam int unsigned JF_JR     = 2;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

    logic [XLEN-1:0] pc_d,   pc_q;
    ifid_t           ifid_d, ifid_q;
    logic [XLEN-1:0] pc_inc_c;
    logic [XLEN-1:0] redirect_pc_c;
    logic            redirect_c;

    // Modulo-2^32 increment; wraps silently past the top of the address space.
    assign pc_inc_c = pc_q + XLEN'(4);

    // jr outranks j/jal, which outranks a taken branch.
    always_comb begin
        redirect_c    = (JumpFlag != JF_W'(0));
        redirect_pc_c = BranchAddr;
        if (JumpFlag[JF_JR]) begin
            redirect_pc_c = JrAddr;
        end else if (JumpFlag[JF_JUMP]) begin
            redirect_pc_c = JumpAddr;
        end else if (JumpFlag[JF_BRANCH]) begin
            redirect_pc_c = BranchAddr;
        end
    end

    // Stall outranks a redirect: ID is frozen and re-presents its request next cycle.
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (Stall) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
        end else if (redirect_c) begin
            pc_d   = redirect_pc_c;
            ifid_d = IFID_BUBBLE;
        end else if (!imem_ready) begin
            pc_d   = pc_q;
            ifid_d = IFID_BUBBLE;
        end else begin
            pc_d           = pc_inc_c;
            ifid_d.instr    = imem_data;
            ifid_d.pc_plus4 = pc_inc_c;
            ifid_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign PC             = pc_q;
    assign Instruction_id = ifid_q.instr;
    assign PC_plus4_id    = ifid_q.pc_plus4;
    assign valid_id       = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed walk through the fetch scenarios, then random stimulus
// compared against a cycle-level reference model of the fetch rules.
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic [2:0]  JumpFlag;
    logic [31:0] BranchAddr, JumpAddr, JrAddr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] imem_addr, PC, Instruction_id, PC_plus4_id;
    logic        valid_id;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc, m_ins, m_p4;
    logic        m_v;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .JumpFlag(JumpFlag),
        .BranchAddr(BranchAddr), .JumpAddr(JumpAddr), .JrAddr(JrAddr),
        .imem_data(imem_data), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .PC(PC), .Instruction_id(Instruction_id), .PC_plus4_id(PC_plus4_id),
        .valid_id(valid_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h2001_0005;
            32'h4:   return 32'h2002_0003;
            32'h8:   return 32'h0022_1820;
            default: return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output after the edge.
    task automatic step(input logic rst, input logic stl, input logic [2:0] jf,
                        input logic [31:0] ba, input logic [31:0] ja,
                        input logic [31:0] jra, input logic rdy);
        @(negedge clk);
        reset = rst; Stall = stl; JumpFlag = jf;
        BranchAddr = ba; JumpAddr = ja; JrAddr = jra; imem_ready = rdy;
        if (rst) begin
            m_pc = RESET_PC; m_ins = NOP_INSTR; m_p4 = 32'h0; m_v = 1'b0;
        end else if (stl) begin
            m_pc = m_pc;
        end else if (jf != 3'b000) begin
            m_pc  = jf[2] ? jra : (jf[1] ? ja : ba);
            m_ins = NOP_INSTR; m_p4 = 32'h0; m_v = 1'b0;
        end else if (!rdy) begin
            m_ins = NOP_INSTR; m_p4 = 32'h0; m_v = 1'b0;
        end else begin
            m_ins = mem_word(m_pc);
            m_p4  = m_pc + 32'd4;
            m_v   = 1'b1;
            m_pc  = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check_eq("pc",    PC,             m_pc);
        check_eq("iaddr", imem_addr,      m_pc);
        check_eq("instr", Instruction_id, m_ins);
        check_eq("pc4",   PC_plus4_id,    m_p4);
        check_eq("valid", {31'b0, valid_id}, {31'b0, m_v});
    endtask

    task automatic fetch();
        step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; JumpFlag = 3'b000;
        BranchAddr = '0; JumpAddr = '0; JrAddr = '0; imem_ready = 1'b1;
        m_pc = RESET_PC; m_ins = NOP_INSTR; m_p4 = '0; m_v = 1'b0;

        // reset and sequential fetch
        step(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1);
        check_eq("rst_pc", PC, 32'h0);
        check_eq("rst_instr", Instruction_id, 32'h0);
        fetch();
        check_eq("seq1_instr", Instruction_id, 32'h2001_0005);
        check_eq("seq1_pc4", PC_plus4_id, 32'h4);
        fetch();
        check_eq("seq2_pc", PC, 32'h8);

        // stall for two cycles at PC=8
        step(1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 1'b1);
        check_eq("stall_pc", PC, 32'h8);
        check_eq("stall_instr", Instruction_id, 32'h2002_0003);
        fetch();
        check_eq("unstall_instr", Instruction_id, 32'h0022_1820);
        check_eq("unstall_pc", PC, 32'hC);
        fetch();

        // redirect priority and flush at PC=0x10
        check_eq("pre_jump_pc", PC, 32'h10);
        step(1'b0, 1'b0, 3'b111, 32'hC0, 32'h80, 32'h40, 1'b1);
        check_eq("jr_pc", PC, 32'h40);
        check_eq("jr_valid", {31'b0, valid_id}, 32'h0);
        fetch();
        check_eq("jr_fetch_pc4", PC_plus4_id, 32'h44);
        step(1'b0, 1'b0, 3'b011, 32'hC0, 32'h80, 32'h40, 1'b1);
        check_eq("j_pc", PC, 32'h80);

        // stall outranks redirect; held flag taken once stall drops
        step(1'b0, 1'b1, 3'b001, 32'h20, 32'h0, 32'h0, 1'b1);
        check_eq("stall_jf_pc", PC, 32'h80);
        step(1'b0, 1'b0, 3'b001, 32'h20, 32'h0, 32'h0, 1'b1);
        check_eq("br_pc", PC, 32'h20);
        fetch();

        // memory not ready for three cycles at 0x24
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
        check_eq("nrdy_pc", PC, 32'h24);
        fetch();

        // PC wrap
        step(1'b0, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        fetch();
        check_eq("wrap_pc", PC, 32'h0);
        check_eq("wrap_pc4", PC_plus4_id, 32'h0);
        for (int i = 0; i < 12; i++) fetch();

        // reset together with stall at 0x30
        check_eq("pre_rst_pc", PC, 32'h30);
        step(1'b1, 1'b1, 3'b100, 32'h0, 32'h0, 32'h44, 1'b1);
        check_eq("midrst_pc", PC, RESET_PC);
        check_eq("midrst_instr", Instruction_id, NOP_INSTR);

        // random stimulus
        for (int i = 0; i < 400; i++) begin
            logic        r, s, rdy;
            logic [2:0]  jf;
            r   = ($urandom_range(63) == 0);
            s   = ($urandom_range(4) == 0);
            rdy = ($urandom_range(5) != 0);
            jf  = ($urandom_range(5) == 0) ? 3'($urandom_range(7)) : 3'b000;
            step(r, s, jf, {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC,
                 ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ({$urandom} & 32'hFFFF_FFFC), rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS `PipelineCPU`, sitting directly upstream of the decode stage. It owns the program counter and presents the current fetch address to instruction memory. It captures the fetched word into the IF/ID register, or inserts a NOP bubble into it. Redirects come from decode via `JumpFlag`; the hazard unit's `Stall` freezes fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000, word injected into IF/ID on flush or bubble (`sll $0,$0,0`).

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `Stall`  input  1  load-use stall from the hazard unit; holds PC and IF/ID.
- `JumpFlag`  input  3  redirect request from ID: bit0 = branch taken, bit1 = j/jal, bit2 = jr.
- `BranchAddr`  input  32  branch target computed in ID.
- `JumpAddr`  input  32  j/jal target computed in ID.
- `JrAddr`  input  32  jr target (forwarded rs) from ID.
- `imem_data`  input  32  instruction word at `imem_addr`, combinational read.
- `imem_ready`  input  1  instruction memory has valid data this cycle.
- `imem_addr`  output  32  fetch address, equal to `PC`.
- `PC`  output  32  current fetch PC (registered).
- `Instruction_id`  output  32  IF/ID instruction register.
- `PC_plus4_id`  output  32  IF/ID PC+4 register, used by decode for branch/jal link.
- `valid_id`  output  1  1 when `Instruction_id` holds a real fetched instruction, 0 for a bubble.

## Operation
- Each clock edge applies exactly one of the following cases, in strict priority order:
  1. `reset`=1: `PC`←`RESET_PC`; `Instruction_id`←`NOP_INSTR`; `PC_plus4_id`←0; `valid_id`←0.
  2. `Stall`=1: PC and all IF/ID registers hold. Stall takes precedence over `JumpFlag` because ID is frozen and its redirect is re-presented next cycle.
  3. `JumpFlag`≠0: `PC`←target, with target priority jr (`JrAddr`) > j (`JumpAddr`) > branch (`BranchAddr`) when several bits are set. The IF/ID registers are flushed: `Instruction_id`←`NOP_INSTR`, `valid_id`←0, `PC_plus4_id`←0. The redirect is taken regardless of `imem_ready`.
  4. `imem_ready`=0: `PC` holds. IF/ID receives a bubble (`NOP_INSTR`, `valid_id`=0, `PC_plus4_id`←0).
  5. Otherwise: `Instruction_id`←`imem_data`; `PC_plus4_id`←`PC`+4; `valid_id`←1; `PC`←`PC`+4.
- Arithmetic: `PC`+4 is a 32-bit modulo add. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
- Target addresses are loaded unmodified. Alignment checking is not performed.
- `imem_addr` is driven combinationally from the `PC` register. No other output has a combinational path from any input.

## Timing
- Fetch latency is one cycle: the word at address A appears on `Instruction_id` the edge after `PC`=A, provided no stall, redirect or not-ready condition occurs.
- Redirect penalty is one bubble. A `JumpFlag` sampled at edge N sets `PC`=target after N and puts NOP in ID for cycle N+1. The target instruction reaches ID after edge N+1.
- Stall is level-sensitive. Each cycle it is high freezes one cycle, and release resumes with no lost or duplicated instruction.
- Reset mid-operation overrides any in-flight stall, redirect or fetch in the same cycle. The first fetch after reset deasserts is from `RESET_PC`.
- All registered outputs are fully defined one edge after `reset` is sampled high. No X must propagate while `reset`=1.

## Test plan
- Reset/sequential fetch: `reset` high for 2 cycles, then low. Memory holds words 0x2001_0005, 0x2002_0003, 0x0022_1820 at 0x0, 0x4, 0x8 with `imem_ready`=1. Required: `PC` = 0, 4, 8, C on successive edges. `Instruction_id` follows one cycle later with `PC_plus4_id` = 4, 8, C and `valid_id`=1.
- Stall: assert `Stall` for 2 cycles while `PC`=0x8. Required: `PC` stays 0x8 and `Instruction_id` stays 0x2002_0003 for both cycles. The next edge loads 0x0022_1820 and `PC`=0xC.
- Redirect priority/flush: at `PC`=0x10, drive `JumpFlag`=3'b111 with `JrAddr`=0x40, `JumpAddr`=0x80, `BranchAddr`=0xC0. Required: `PC`=0x40, `Instruction_id`=0, `valid_id`=0. The next edge fetches from 0x40. Repeat with 3'b011: required `PC`=0x80.
- Stall vs redirect: `Stall`=1 and `JumpFlag`=3'b001 with `BranchAddr`=0x20. Required: no PC change. The next cycle, with `Stall`=0 and the flag held, `PC`=0x20.
- Memory not ready and wrap: `imem_ready`=0 for 3 cycles at `PC`=0x24. Required: `PC` holds 0x24 and 3 bubbles with `valid_id`=0. Separately, jump to 0xFFFF_FFFC, then fetch. Required: `PC` wraps to 0x0 and `PC_plus4_id`=0x0.
- Reset mid-stall: `reset` and `Stall` high together at `PC`=0x30. Required: `PC`=`RESET_PC` and `Instruction_id`=`NOP_INSTR` after that edge.
